snoop_bus_mem_responder: RTL

- Responder end of the shared snooping bus between the four per-core caches.
- Arbitrates among cache-side RdMs/WrMs/WrBk requests and broadcasts the winning transaction for snooping.
- Collects shared responses, services the request from a word-addressed backing memory, and returns the fill value with readyToRead.
- Sits between the cache array and main memory, as the counterpart to the caches' bus-request outputs.

---
 rtl/snoop_bus_mem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_mem_responder.sv
// Responder end of the shared snooping bus: round-robin arbitration, snoop broadcast,
// shared-response collection and service of RdMs/WrMs/WrBk from a word-addressed memory.
module snoop_bus_mem_responder #(
    parameter int NUM_PROCS   = 4,
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*NUM_PROCS-1:0]  req_cmd,
    input  logic [32*NUM_PROCS-1:0] req_addr,
    input  logic [32*NUM_PROCS-1:0] req_wdata,
    input  logic [NUM_PROCS-1:0]    snoop_shared,
    output logic [NUM_PROCS-1:0]    grant,
    output logic                    bus_busy,
    output logic [1:0]              proc_ID_out,
    output logic [31:0]             address_out,
    output logic [1:0]              snoop_cmd,
    output logic [31:0]             value_out,
    output logic                    readyToRead,
    output logic                    shared_out,
    output logic [NUM_PROCS-1:0]    req_done
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SNOOP = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] CMD_RDMS = 2'b01;
    localparam logic [1:0] CMD_WRBK = 2'b11;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("snoop_bus_mem_responder: MEM_LATENCY must be in 1..15");
    end
    if (NUM_PROCS < 1 || NUM_PROCS > 4) begin : g_bad_procs
        $error("snoop_bus_mem_responder: NUM_PROCS must be in 1..4");
    end
    if ((1 << AW) != MEM_WORDS) begin : g_bad_words
        $error("snoop_bus_mem_responder: MEM_WORDS must be a power of two");
    end

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        shared_q, shared_d;

    logic [NUM_PROCS-1:0] req_valid;
    logic [NUM_PROCS-1:0] grant_vec;
    logic                 win_found;
    logic [1:0]           win_id;
    int unsigned          cand;
    logic [AW-1:0]        word_idx;
    logic                 mem_we;
    logic [31:0]          mem_rd [MEM_WORDS];

    assign grant_vec = NUM_PROCS'(1) << id_q;
    assign word_idx  = addr_q[AW+1:2];
    // Reset gates the write so a WrBk interrupted at its RESP edge leaves memory untouched.
    assign mem_we    = (state_q == S_RESP) && (cmd_q == CMD_WRBK) && !rst;

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NUM_PROCS; i++) begin
            req_valid[i] = |req_cmd[2*i +: 2];
        end
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_PROCS; i++) begin
            cand = (32'(ptr_q) + i) % NUM_PROCS;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = 2'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shared_d = shared_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_SNOOP;
                    id_d    = win_id;
                    cmd_d   = req_cmd[2*win_id +: 2];
                    addr_d  = req_addr[32*win_id +: 32];
                    wdata_d = req_wdata[32*win_id +: 32];
                end
            end
            S_SNOOP: begin
                shared_d = (cmd_q == CMD_RDMS) && |(snoop_shared & ~grant_vec);
                cnt_d    = CNT_LOAD;
                state_d  = S_MEM;
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ptr_d   = (id_q == 2'(NUM_PROCS - 1)) ? 2'd0 : id_q + 2'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shared_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shared_q <= shared_d;
        end
    end

    // Backing store: each word powers up holding its own index and is never cleared by rst.
    for (genvar k = 0; k < MEM_WORDS; k++) begin : g_mem
        logic [31:0] word_q = 32'(k);
        logic [31:0] word_d;

        always_comb begin
            word_d = word_q;
            if (mem_we && (word_idx == AW'(k))) begin
                word_d = wdata_q;
            end
        end

        always_ff @(posedge clk) begin
            word_q <= word_d;
        end

        assign mem_rd[k] = word_q;
    end

    always_comb begin
        grant       = '0;
        bus_busy    = 1'b0;
        proc_ID_out = '0;
        address_out = '0;
        snoop_cmd   = '0;
        value_out   = '0;
        readyToRead = 1'b0;
        shared_out  = 1'b0;
        req_done    = '0;
        if (state_q != S_IDLE) begin
            grant       = grant_vec;
            bus_busy    = 1'b1;
            proc_ID_out = id_q;
            address_out = addr_q;
            snoop_cmd   = cmd_q;
        end
        if (state_q == S_RESP) begin
            req_done = grant_vec;
            if (cmd_q != CMD_WRBK) begin
                readyToRead = 1'b1;
                value_out   = mem_rd[word_idx];
                shared_out  = shared_q;
            end
        end
    end

endmodule
